// File: rtl/tone_voice_dispatcher.sv
// rtl/tone_voice_dispatcher.sv - tone-word FIFO feeding sample-aligned voice register updates
module tone_voice_dispatcher #(
    parameter int DEPTH  = 16,
    parameter int VOICES = 4,
    parameter int INC_W  = 24
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [31:0]             tone_in,
    input  logic                    ld_fifo,
    input  logic                    sample_tick,
    input  logic                    flush,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    run,
    output logic [VOICES*INC_W-1:0] voice_inc,
    output logic [VOICES-1:0]       voice_gate,
    output logic                    overflow,
    output logic                    bad_voice
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    logic [31:0]             mem_q [DEPTH];
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [AW:0]             count_q, count_d;
    logic                    ld_q, armed_q, ovf_q;
    state_t                  state_q;
    logic [31:0]             rdata_q, held_q;
    logic [VOICES*INC_W-1:0] inc_q;
    logic [VOICES-1:0]       gate_q;
    logic                    bad_q;

    logic       wr_edge, wr_ok, pop, apply;
    logic [6:0] held_idx;

    assign fifo_full  = (count_q == FULL_LVL);
    assign fifo_empty = (count_q == '0);
    assign fifo_level = count_q;
    assign voice_inc  = inc_q;
    assign voice_gate = gate_q;
    assign overflow   = ovf_q;
    assign bad_voice  = bad_q;
    assign run        = (|gate_q) | ~fifo_empty | (state_q != IDLE);

    // armed_q keeps a strobe already high when reset releases from looking like an edge
    assign wr_edge  = ld_fifo & ~ld_q & armed_q;
    assign wr_ok    = wr_edge & ~fifo_full & ~flush;
    assign pop      = (state_q == IDLE) & ~fifo_empty & ~flush;
    assign apply    = (state_q == HOLD) & sample_tick & ~flush;
    assign held_idx = held_q[30:24];

    always_comb begin
        count_d = count_q;
        if (wr_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ld_q    <= 1'b0;
            armed_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ld_q    <= ld_fifo;
            armed_q <= 1'b1;
            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (wr_ok) wptr_q <= wptr_q + 1'b1;
                if (pop)   rptr_q <= rptr_q + 1'b1;
                count_q <= count_d;
                if (wr_edge && fifo_full) ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (wr_ok) mem_q[wptr_q] <= tone_in;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            held_q  <= '0;
            inc_q   <= '0;
            gate_q  <= '0;
            bad_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            gate_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        rdata_q <= mem_q[rptr_q];
                        state_q <= READ;
                    end
                end
                READ: begin
                    held_q  <= rdata_q;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (apply) begin
                        if (int'(held_idx) < VOICES) begin
                            for (int v = 0; v < VOICES; v++) begin
                                if (held_idx == 7'(v)) begin
                                    gate_q[v]                <= held_q[31];
                                    inc_q[v*INC_W +: INC_W] <= held_q[INC_W-1:0];
                                end
                            end
                        end else if (held_idx == 7'h7F && !held_q[31]) begin
                            gate_q <= '0;
                        end else begin
                            bad_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_voice_dispatcher.sv
// tb/tb_tone_voice_dispatcher.sv - directed self-checking bench for tone_voice_dispatcher
module tb_tone_voice_dispatcher;
    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [31:0] tone_in;
    logic        ld_fifo;
    logic        sample_tick;
    logic        flush;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_level;
    logic        run;
    logic [95:0] voice_inc;
    logic [3:0]  voice_gate;
    logic        overflow;
    logic        bad_voice;

    int n_checks = 0;
    int n_errors = 0;

    tone_voice_dispatcher #(.DEPTH(16), .VOICES(4), .INC_W(24)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .tone_in     (tone_in),
        .ld_fifo     (ld_fifo),
        .sample_tick (sample_tick),
        .flush       (flush),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_level  (fifo_level),
        .run         (run),
        .voice_inc   (voice_inc),
        .voice_gate  (voice_gate),
        .overflow    (overflow),
        .bad_voice   (bad_voice)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        tone_in = w;
        ld_fifo = 1'b1;
        step(1);
        ld_fifo = 1'b0;
        tone_in = 32'hDEAD_BEEF;
        step(1);
    endtask

    // Into an idle, empty pipeline: write, pop, reach HOLD, apply on tick
    task automatic send_and_apply(input logic [31:0] w);
        write_word(w);
        step(1);
        pulse_tick();
    endtask

    function automatic logic [23:0] vinc(input int v);
        return voice_inc[v*24 +: 24];
    endfunction

    initial begin
        reset_reset = 1'b1;
        tone_in     = '0;
        ld_fifo     = 1'b0;
        sample_tick = 1'b0;
        flush       = 1'b0;
        step(2);
        check("rst_level", fifo_level, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_run", run, 0);
        check("rst_gate", voice_gate, 0);
        check("rst_inc", voice_inc, 0);
        check("rst_flags", {overflow, bad_voice}, 0);
        reset_reset = 1'b0;
        step(2);

        // Single word: latency and tick alignment
        tone_in = 32'h8000_1234;
        ld_fifo = 1'b1;
        step(1);
        check("t1_level_after_write", fifo_level, 1);
        check("t1_empty_after_write", fifo_empty, 0);
        check("t1_run", run, 1);
        ld_fifo = 1'b0;
        step(1);
        check("t1_level_after_pop", fifo_level, 0);
        step(4);
        check("t1_no_apply_without_tick", voice_gate, 0);
        check("t1_inc_not_yet", voice_inc, 0);
        pulse_tick();
        check("t1_gate", voice_gate, 4'b0001);
        check("t1_inc", voice_inc, 96'h001234);

        // Held strobe writes once with the edge-cycle value
        tone_in = 32'h8100_00AA;
        ld_fifo = 1'b1;
        step(1);
        check("t2_level_edge", fifo_level, 1);
        for (int k = 0; k < 9; k++) begin
            tone_in = 32'h8100_00B0 + k;
            step(1);
        end
        ld_fifo = 1'b0;
        tone_in = '0;
        check("t2_level_held", fifo_level, 0);
        pulse_tick();
        check("t2_v1_inc", vinc(1), 24'h0000AA);
        check("t2_gate", voice_gate, 4'b0011);
        step(4);
        pulse_tick();
        check("t2_v1_inc_stable", vinc(1), 24'h0000AA);
        check("t2_empty", fifo_empty, 1);

        // Overfill: w0 sits in HOLD, w1..w16 fill the FIFO, w17 dropped
        for (int i = 0; i < 18; i++) begin
            write_word(32'h8000_0000 | (32'(i % 4) << 24) | (32'h100 + 32'(i)));
        end
        check("t3_full", fifo_full, 1);
        check("t3_level", fifo_level, 16);
        check("t3_overflow", overflow, 1);
        for (int i = 0; i < 17; i++) begin
            pulse_tick();
            check($sformatf("t3_order_%0d", i), vinc(i % 4), 24'h100 + 24'(i));
            step(3);
        end
        check("t3_drained", fifo_empty, 1);
        pulse_tick();
        check("t3_dropped_word", voice_inc, {24'h10F, 24'h10E, 24'h10D, 24'h110});
        check("t3_gates", voice_gate, 4'hF);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t3_flush_gate", voice_gate, 0);
        check("t3_flush_ovf", overflow, 0);
        check("t3_flush_inc", voice_inc, {24'h10F, 24'h10E, 24'h10D, 24'h110});

        // Bad voice index leaves other voices alone
        send_and_apply(32'h8000_0001);
        send_and_apply(32'h8100_0002);
        send_and_apply(32'h8300_0003);
        send_and_apply(32'h8200_0010);
        check("t4_v2", vinc(2), 24'h10);
        send_and_apply(32'h0400_0020);
        check("t4_bad", bad_voice, 1);
        check("t4_gate", voice_gate, 4'hF);
        check("t4_inc", voice_inc, {24'h3, 24'h10, 24'h2, 24'h1});

        // All-notes-off
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t5_bad_cleared", bad_voice, 0);
        send_and_apply(32'h8000_0001);
        send_and_apply(32'h8100_0002);
        send_and_apply(32'h8200_0010);
        send_and_apply(32'h8300_0003);
        check("t5_gates_on", voice_gate, 4'hF);
        send_and_apply(32'h7F00_0000);
        check("t5_gates_off", voice_gate, 0);
        check("t5_inc_kept", voice_inc, {24'h3, 24'h10, 24'h2, 24'h1});
        check("t5_no_bad", bad_voice, 0);
        check("t5_run", run, 0);

        // Simultaneous write+pop, then flush in HOLD with a coincident tick and write
        write_word(32'h8100_0055);
        write_word(32'h8000_0066);
        write_word(32'h8200_0077);
        check("t6_level2", fifo_level, 2);
        pulse_tick();
        check("t6_a_applied", vinc(1), 24'h55);
        tone_in = 32'h8300_0088;
        ld_fifo = 1'b1;
        step(1);
        check("t6_wr_pop_level", fifo_level, 2);
        ld_fifo = 1'b0;
        step(2);
        write_word(32'h8000_0099);
        check("t6_level3", fifo_level, 3);
        flush       = 1'b1;
        sample_tick = 1'b1;
        tone_in     = 32'h8300_00FF;
        ld_fifo     = 1'b1;
        step(1);
        flush       = 1'b0;
        sample_tick = 1'b0;
        ld_fifo     = 1'b0;
        check("t6_flush_level", fifo_level, 0);
        check("t6_flush_empty", fifo_empty, 1);
        check("t6_flush_gate", voice_gate, 0);
        check("t6_flush_flags", {overflow, bad_voice}, 0);
        check("t6_flush_inc", voice_inc, {24'h3, 24'h10, 24'h55, 24'h1});
        for (int k = 0; k < 3; k++) begin
            step(3);
            pulse_tick();
        end
        check("t6_held_discarded", voice_inc, {24'h3, 24'h10, 24'h55, 24'h1});
        check("t6_post_level", fifo_level, 0);
        check("t6_post_run", run, 0);

        // Asynchronous reset while a word is held; strobe high across release
        write_word(32'h8000_00AB);
        step(1);
        ld_fifo = 1'b1;
        #2;
        reset_reset = 1'b1;
        #1;
        check("t7_async_inc", voice_inc, 0);
        check("t7_async_empty", fifo_empty, 1);
        check("t7_async_run", run, 0);
        step(1);
        reset_reset = 1'b0;
        step(3);
        check("t7_held_strobe_level", fifo_level, 0);
        pulse_tick();
        check("t7_no_partial", {voice_gate, voice_inc}, 0);
        ld_fifo = 1'b0;
        step(1);
        send_and_apply(32'h8200_0042);
        check("t7_rearm_inc", voice_inc, {24'h0, 24'h42, 24'h0, 24'h0});
        check("t7_rearm_gate", voice_gate, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tone_voice_dispatcher.md
TONE_VOICE_DISPATCHER -- requirements
Module: tone_voice_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in words, power of two and at least 2.
REQ-002 SHALL have parameter VOICES, default 4, number of voice channels, from 1 to 64.
REQ-003 SHALL have parameter INC_W, default 24, phase-increment width in bits, at most 24.
REQ-004 SHALL use one clock, clk_clk, input, 1 bit; all logic is rising-edge.
REQ-005 SHALL have reset_reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have tone_in, input, 32 bits: tone word from the CPU output port.
REQ-007 SHALL have ld_fifo, input, 1 bit: CPU load strobe, level-held by software.
REQ-008 SHALL have sample_tick, input, 1 bit: one-cycle pulse at the audio sample rate.
REQ-009 SHALL have flush, input, 1 bit: synchronous clear.
REQ-010 SHALL have fifo_full, output, 1 bit, and fifo_empty, output, 1 bit.
REQ-011 SHALL have fifo_level, output, clog2(DEPTH)+1 bits: words stored.
REQ-012 SHALL have run, output, 1 bit: high when any gate is set, the FIFO is non-empty or the FSM is not IDLE.
REQ-013 SHALL have voice_inc, output, VOICES*INC_W bits; voice v occupies bits [v*INC_W +: INC_W].
REQ-014 SHALL have voice_gate, output, VOICES bits: note-on per voice.
REQ-015 SHALL have overflow, output, 1 bit, and bad_voice, output, 1 bit; both are sticky error flags.

Function
REQ-016 SHALL decode tone word fields as: bit 31 is the gate; bits 30:24 are the voice index; bits INC_W-1:0 are the phase increment.
REQ-017 SHALL register ld_fifo and treat only a 0->1 edge as a write; tone_in is sampled in that edge cycle, so a held strobe writes exactly once.
REQ-018 SHALL drop a write when fifo_full is high and set overflow, including when a pop occurs in the same cycle.
REQ-019 SHALL update fifo_level, fifo_full and fifo_empty the cycle after each write or pop.
REQ-020 SHALL leave fifo_level unchanged when an accepted write and a pop occur in the same cycle.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH.
REQ-022 SHALL implement FSM states IDLE, READ and HOLD.
REQ-023 SHALL transition IDLE->READ when the FIFO is non-empty, popping one word in that transition.
REQ-024 SHALL transition READ->HOLD unconditionally, latching the popped word (the storage RAM has synchronous read).
REQ-025 SHALL, in HOLD, apply the held word on the first cycle with sample_tick=1 and then go to IDLE; with no tick, HOLD persists.
REQ-026 SHALL make at most one voice update per sample_tick, so all changes land on sample boundaries.
REQ-027 SHALL, on apply with index < VOICES, load that voice's increment and gate in the same register update.
REQ-028 SHALL, on apply with index 0x7F and gate 0, clear all gates and keep all increments (all-notes-off); this does not set bad_voice.
REQ-029 SHALL, on apply with any other index >= VOICES, change no voice and set bad_voice.
REQ-030 SHALL make applied values visible on the outputs in the cycle after the tick cycle.
REQ-031 SHALL give end-to-end latency as follows: for a write edge at cycle t into an empty FIFO with the FSM in IDLE, the word reaches HOLD at t+3 and is applied on the first tick at or after t+3.
REQ-032 SHALL, on flush, in the next cycle: empty the FIFO, force the FSM to IDLE discarding any held word, clear all gates, overflow and bad_voice, and retain voice_inc.
REQ-033 SHALL give flush priority over a coincident write edge; that word is dropped and overflow is not set.
REQ-034 SHALL give flush priority over a coincident tick; no apply occurs.

Reset
REQ-035 SHALL, while reset_reset is high, immediately drive all outputs to zero, except fifo_empty which is 1.
REQ-036 SHALL, while reset_reset is high, hold the FSM in IDLE and both pointers at 0.
REQ-037 SHALL, while reset_reset is high, also clear the ld_fifo edge register; a strobe already high at reset release does not write.
REQ-038 SHALL allow reset mid-operation to abandon any held word with no partial voice update.

Verification
REQ-039 SHALL cover: write 0x8000_1234 with ticks every 8 cycles -> voice 0 inc=0x001234, gate=1 after the first tick at or after t+3; fifo_level returns to 0.
REQ-040 SHALL cover: ld_fifo held high for 10 cycles with a varying tone_in -> exactly one word is stored, the value from the edge cycle.
REQ-041 SHALL cover: DEPTH+2 write edges with no ticks -> fifo_full=1, level=DEPTH, overflow=1; the first DEPTH words are then applied in order, one per tick.
REQ-042 SHALL cover: words 0x8200_0010 then 0x0400_0020 with VOICES=4 -> voice 2 updated, bad_voice=1, voice_gate bits 0, 1 and 3 unchanged.
REQ-043 SHALL cover: gates 0..3 set, then word 0x7F00_0000 -> voice_gate=0, all increments retained, run=0 once the FIFO is empty.
REQ-044 SHALL cover: flush while in HOLD with 3 words queued -> level=0, gates=0, flags=0, the held word is never applied, voice_inc unchanged.
